// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcodes, flag masks, condition codes and FSM states for the ALU issuer
package ula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADC    = 5'b00001;
    localparam logic [4:0] OP_SBB    = 5'b00011;
    localparam logic [4:0] OP_INC    = 5'b00100;
    localparam logic [4:0] OP_SUB    = 5'b00101;
    localparam logic [4:0] OP_DEC    = 5'b00110;
    localparam logic [4:0] OP_SHL    = 5'b01000;
    localparam logic [4:0] OP_SHR    = 5'b01001;
    localparam logic [4:0] OP_ZERO   = 5'b10000;
    localparam logic [4:0] OP_AND    = 5'b10001;
    localparam logic [4:0] OP_OR     = 5'b10010;
    localparam logic [4:0] OP_MOVA   = 5'b10011;
    localparam logic [4:0] OP_MOVB   = 5'b11111;
    localparam logic [4:0] OP_ILL_0  = 5'b00010;
    localparam logic [4:0] OP_ILL_1  = 5'b00111;
    localparam logic [4:0] OP_ILL_LO = 5'b01010;
    localparam logic [4:0] OP_ILL_HI = 5'b01111;

    // Flag vector layout {Z,C,S,O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    localparam logic [3:0] MASK_ZCSO = 4'b1111;
    localparam logic [3:0] MASK_ZCS  = 4'b1110;
    localparam logic [3:0] MASK_ZS   = 4'b1010;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_C      = 3'b011;
    localparam logic [2:0] COND_NC     = 3'b100;
    localparam logic [2:0] COND_S      = 3'b101;
    localparam logic [2:0] COND_O      = 3'b110;
    localparam logic [2:0] COND_LT     = 3'b111;

    function automatic logic op_legal(input logic [4:0] op);
        return !(op == OP_ILL_0 || op == OP_ILL_1 || (op >= OP_ILL_LO && op <= OP_ILL_HI));
    endfunction

    function automatic logic [3:0] flag_mask(input logic [4:0] op);
        logic [3:0] m;
        if (op == OP_ZERO || op == OP_MOVA || op == OP_MOVB)
            m = MASK_NONE;
        else if (op == OP_SHL || op == OP_SHR)
            m = MASK_ZCS;
        else if (op[4])
            m = MASK_ZS;
        else if (op <= OP_DEC)
            m = MASK_ZCSO;
        else
            m = MASK_NONE;
        return m;
    endfunction

endpackage

// File: rtl/ula_flag_reg.sv
// rtl/ula_flag_reg.sv - masked flag register and branch condition evaluator
module ula_flag_reg
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       commit,
    input  logic [3:0] mask,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_s,
    input  logic       alu_o,
    input  logic [2:0] cond_sel,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_s,
    output logic       flag_o,
    output logic       cond_true
);

    logic [3:0] flags;
    logic [3:0] fresh;

    assign fresh = {alu_z, alu_c, alu_s, alu_o};

    // Bits the ALU did not refresh for this op keep their committed value
    always_ff @(posedge clk) begin
        if (!rst_n)
            flags <= 4'b0000;
        else if (commit)
            flags <= (flags & ~mask) | (fresh & mask);
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_s = flags[FLAG_S];
    assign flag_o = flags[FLAG_O];

    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flag_z;
            COND_NZ:     cond_true = !flag_z;
            COND_C:      cond_true = flag_c;
            COND_NC:     cond_true = !flag_c;
            COND_S:      cond_true = flag_s;
            COND_O:      cond_true = flag_o;
            COND_LT:     cond_true = flag_s ^ flag_o;
            default:     cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_issue_ctrl.sv
// rtl/ula_issue_ctrl.sv - four-cycle ALU instruction issuer with register file read/writeback
module ula_issue_ctrl
    import ula_pkg::*;
#(
    parameter int bits_palavra = 16,
    parameter int REG_ADDR_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [4:0]              instr_op,
    input  logic [REG_ADDR_W-1:0]   instr_rd,
    input  logic [REG_ADDR_W-1:0]   instr_ra,
    input  logic [REG_ADDR_W-1:0]   instr_rb,
    output logic [REG_ADDR_W-1:0]   rf_addr_a,
    output logic [REG_ADDR_W-1:0]   rf_addr_b,
    input  logic [bits_palavra-1:0] rf_data_a,
    input  logic [bits_palavra-1:0] rf_data_b,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [bits_palavra-1:0] rf_wdata,
    output logic [4:0]              alu_controle,
    output logic [bits_palavra-1:0] alu_opA,
    output logic [bits_palavra-1:0] alu_opB,
    input  logic [bits_palavra-1:0] alu_result,
    input  logic                    alu_Z,
    input  logic                    alu_C,
    input  logic                    alu_S,
    input  logic                    alu_O,
    output logic                    flag_z,
    output logic                    flag_c,
    output logic                    flag_s,
    output logic                    flag_o,
    input  logic [2:0]              cond_sel,
    output logic                    cond_true,
    output logic                    op_done,
    output logic                    op_err
);

    state_t                  state;
    logic [4:0]              op_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [REG_ADDR_W-1:0]   ra_q;
    logic [REG_ADDR_W-1:0]   rb_q;
    logic [bits_palavra-1:0] opa_q;
    logic [bits_palavra-1:0] opb_q;
    logic [bits_palavra-1:0] res_q;
    logic [3:0]              aluf_q;
    logic                    err_q;
    logic                    accept;

    assign instr_ready = (state == ST_IDLE);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_ZERO;
            rd_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            aluf_q <= 4'b0000;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_legal(instr_op)) begin
                            op_q  <= instr_op;
                            rd_q  <= instr_rd;
                            ra_q  <= instr_ra;
                            rb_q  <= instr_rb;
                            state <= ST_READ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    opa_q <= rf_data_a;
                    opb_q <= rf_data_b;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q  <= alu_result;
                    aluf_q <= {alu_Z, alu_C, alu_S, alu_O};
                    state  <= ST_WB;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Addresses go out in the accept cycle too, so a registered-read file has data ready in READ
    assign rf_addr_a = (state == ST_IDLE) ? instr_ra : ra_q;
    assign rf_addr_b = (state == ST_IDLE) ? instr_rb : rb_q;

    assign alu_controle = op_q;
    assign alu_opA      = opa_q;
    assign alu_opB      = opb_q;

    assign rf_we    = (state == ST_WB);
    assign op_done  = (state == ST_WB);
    assign rf_waddr = rd_q;
    assign rf_wdata = res_q;
    assign op_err   = err_q;

    ula_flag_reg u_flag_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit   (state == ST_WB),
        .mask     (flag_mask(op_q)),
        .alu_z    (aluf_q[FLAG_Z]),
        .alu_c    (aluf_q[FLAG_C]),
        .alu_s    (aluf_q[FLAG_S]),
        .alu_o    (aluf_q[FLAG_O]),
        .cond_sel (cond_sel),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_s   (flag_s),
        .flag_o   (flag_o),
        .cond_true(cond_true)
    );

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// tb/tb_ula_issue_ctrl.sv - bench for ula_issue_ctrl with register file, ALU and reference model
module tb_ula_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd, instr_ra, instr_rb;
    logic [2:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_data_a, rf_data_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  alu_controle;
    logic [15:0] alu_opA, alu_opB, alu_result;
    logic        alu_Z, alu_C, alu_S, alu_O;
    logic        flag_z, flag_c, flag_s, flag_o;
    logic [2:0]  cond_sel;
    logic        cond_true;
    logic        op_done, op_err;

    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] rf_mem [8];

    logic [15:0] ref_rf [8];
    logic [3:0]  ref_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula_issue_ctrl #(.bits_palavra(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_controle(alu_controle), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_result(alu_result), .alu_Z(alu_Z), .alu_C(alu_C), .alu_S(alu_S), .alu_O(alu_O),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .flag_o(flag_o),
        .cond_sel(cond_sel), .cond_true(cond_true),
        .op_done(op_done), .op_err(op_err)
    );

    // Register file with one-cycle registered read
    always @(posedge clk) begin
        rf_data_a <= rf_mem[rf_addr_a];
        rf_data_b <= rf_mem[rf_addr_b];
        if (pre_we)
            rf_mem[pre_addr] <= pre_data;
        else if (rf_we)
            rf_mem[rf_waddr] <= rf_wdata;
    end

    // Behavioural ALU: returns {Z,C,S,O,result}; C/O are junk where the op does not define them
    function automatic logic [19:0] alu_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] bb, r;
        logic        cin, c, o;
        c = ^a;
        o = ~^b;
        r = a;
        if (op inside {5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110}) begin
            case (op)
                5'b00000: begin bb = b;        cin = 1'b0; end
                5'b00001: begin bb = b;        cin = 1'b1; end
                5'b00011: begin bb = ~b;       cin = 1'b0; end
                5'b00100: begin bb = 16'h0000; cin = 1'b1; end
                5'b00101: begin bb = ~b;       cin = 1'b1; end
                default:  begin bb = 16'hFFFF; cin = 1'b0; end
            endcase
            s = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
            r = s[15:0];
            c = s[16];
            o = (a[15] == bb[15]) && (r[15] != a[15]);
        end else if (op == 5'b01000) begin
            r = a << 1; c = a[15];
        end else if (op == 5'b01001) begin
            r = a >> 1; c = a[0];
        end else if (op == 5'b10000) r = 16'h0000;
        else if (op == 5'b10011) r = a;
        else if (op == 5'b11111) r = b;
        else if (op == 5'b10001) r = a & b;
        else if (op == 5'b10010) r = a | b;
        else if (op[4])          r = a ^ b;
        return {(r == 16'h0000), c, r[15], o, r};
    endfunction

    always_comb {alu_Z, alu_C, alu_S, alu_O, alu_result} = alu_ref(alu_controle, alu_opA, alu_opB);

    function automatic logic ref_legal(input logic [4:0] op);
        return !(op inside {5'b00010, 5'b00111, [5'b01010:5'b01111]});
    endfunction

    function automatic logic [3:0] ref_mask(input logic [4:0] op);
        if (op inside {5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110}) return 4'b1111;
        if (op inside {5'b01000, 5'b01001}) return 4'b1110;
        if (op inside {5'b10001, 5'b10010, 5'b10100, 5'b10101, [5'b10110:5'b11110]}) return 4'b1010;
        return 4'b0000;
    endfunction

    function automatic logic ref_cond(input logic [2:0] sel, input logic [3:0] f);
        case (sel)
            3'd0: return 1'b1;
            3'd1: return f[3];
            3'd2: return !f[3];
            3'd3: return f[2];
            3'd4: return !f[2];
            3'd5: return f[1];
            3'd6: return f[0];
            default: return f[1] ^ f[0];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction from a negedge and follow it to completion against the model
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [2:0] csel,
                         output logic [15:0] got_wdata, output logic [3:0] got_flags, output logic got_cond);
        logic [19:0] r;
        logic [3:0]  m;
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        check("ready_before_issue", instr_ready, 1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; cond_sel = csel;
        got_wdata = 16'hxxxx;
        @(negedge clk);
        instr_valid = 1'b0; instr_op = 5'($urandom); instr_rd = 3'($urandom);
        instr_ra = 3'($urandom); instr_rb = 3'($urandom);
        if (!ref_legal(op)) begin
            check("err_pulse", op_err, 1);
            check("err_no_we", rf_we, 0);
            check("err_ready", instr_ready, 1);
            check("err_flags_hold", {flag_z, flag_c, flag_s, flag_o}, ref_flags);
            @(negedge clk);
            check("err_single_pulse", op_err, 0);
        end else begin
            check("read_busy", instr_ready, 0);
            check("read_no_we", rf_we, 0);
            @(negedge clk);
            check("exec_no_we", rf_we | op_done, 0);
            check("exec_ctrl", alu_controle, op);
            @(negedge clk);
            r = alu_ref(op, ref_rf[ra], ref_rf[rb]);
            check("wb_we", rf_we, 1);
            check("wb_done", op_done, 1);
            check("wb_addr", rf_waddr, rd);
            check("wb_data", rf_wdata, r[15:0]);
            got_wdata = rf_wdata;
            ref_rf[rd] = r[15:0];
            m = ref_mask(op);
            ref_flags = (ref_flags & ~m) | (r[19:16] & m);
            @(negedge clk);
            check("post_we", rf_we | op_done, 0);
            check("post_ready", instr_ready, 1);
        end
        check("flags", {flag_z, flag_c, flag_s, flag_o}, ref_flags);
        check("cond", cond_true, ref_cond(csel, ref_flags));
        got_flags = {flag_z, flag_c, flag_s, flag_o};
        got_cond  = cond_true;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd, ra, rb, csel;
        logic [15:0] wdata;
        logic [3:0]  flags;
        logic        cond;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [15:0] w;
        logic [3:0]  f;
        logic        c;
        int acc, dn;

        vecs[0] = '{5'b00000, 3'd3, 3'd1, 3'd2, 3'b111, 16'h8000, 4'b0011, 1'b0};
        vecs[1] = '{5'b00101, 3'd6, 3'd4, 3'd4, 3'b001, 16'h0000, 4'b1100, 1'b1};
        vecs[2] = '{5'b10011, 3'd7, 3'd1, 3'd2, 3'b001, 16'h7FFF, 4'b1100, 1'b1};
        vecs[3] = '{5'b00000, 3'd3, 3'd1, 3'd2, 3'b010, 16'h8000, 4'b0011, 1'b1};
        vecs[4] = '{5'b01000, 3'd0, 3'd5, 3'd0, 3'b110, 16'h0002, 4'b0101, 1'b1};
        vecs[5] = '{5'b10001, 3'd2, 3'd5, 3'd4, 3'b011, 16'h0001, 4'b0101, 1'b1};
        vecs[6] = '{5'b00000, 3'd1, 3'd1, 3'd1, 3'b100, 16'hFFFE, 4'b0011, 1'b1};

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 5'b0; instr_rd = 3'd0;
        instr_ra = 3'd0; instr_rb = 3'd0; cond_sel = 3'd0; pre_we = 1'b0; pre_addr = 3'd0; pre_data = 16'h0;
        ref_flags = 4'b0000;

        // Reset held while preloading the register file
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 3'(i);
            case (i)
                1: pre_data = 16'h7FFF;
                2: pre_data = 16'h0001;
                4: pre_data = 16'h0005;
                5: pre_data = 16'h8001;
                default: pre_data = 16'h0000;
            endcase
            ref_rf[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_flags", {flag_z, flag_c, flag_s, flag_o}, 4'b0000);
        check("rst_we", rf_we, 0);
        check("rst_done_err", {op_done, op_err}, 2'b00);
        check("rst_alu_ctrl", alu_controle, 5'b10000);
        check("rst_alu_ops", {alu_opA, alu_opB}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].csel, w, f, c);
            check($sformatf("vec%0d_wdata", i), w, vecs[i].wdata);
            check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
            check($sformatf("vec%0d_cond", i), c, vecs[i].cond);
        end

        issue(5'b00010, 3'd3, 3'd1, 3'd2, 3'b111, w, f, c);
        issue(5'b01100, 3'd3, 3'd1, 3'd2, 3'b110, w, f, c);

        // instr_valid held high: accepts only when idle, one per four cycles
        acc = 0; dn = 0;
        instr_valid = 1'b1; instr_op = 5'b10000; instr_rd = 3'd7; instr_ra = 3'd0; instr_rb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (instr_ready) acc++;
            if (op_done) dn++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        ref_rf[7] = 16'h0000;
        check("burst_accepts", acc, 2);
        check("burst_done", dn, 2);
        check("burst_flags", {flag_z, flag_c, flag_s, flag_o}, ref_flags);

        // Reset while in EXEC discards the op
        instr_valid = 1'b1; instr_op = 5'b00000; instr_rd = 3'd6; instr_ra = 3'd1; instr_rb = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_flags_set", {flag_z, flag_c, flag_s, flag_o}, ref_flags);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_flags = 4'b0000;
        check("exec_rst_we", rf_we, 0);
        check("exec_rst_done", op_done, 0);
        check("exec_rst_flags", {flag_z, flag_c, flag_s, flag_o}, 4'b0000);
        check("exec_rst_ready", instr_ready, 1);
        @(negedge clk);
        check("exec_rst_no_late_we", rf_we | op_done, 0);

        for (int i = 0; i < 40; i++)
            issue(5'($urandom_range(0, 31)), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), w, f, c);

        for (int i = 0; i < 8; i++)
            check($sformatf("rf_final_r%0d", i), rf_mem[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
